// File: rtl/barrel_pkg.sv
// Shared thread-id sizing for the barrel core: thread count, tid type and
// the width of the per-thread block countdown.
package barrel_pkg;

  localparam int BITS_THREADS   = 3;
  localparam int NUM_THREADS    = 2 ** BITS_THREADS;
  localparam int WAIT_CNT_WIDTH = 4;

  typedef logic [BITS_THREADS-1:0] tid_t;

endpackage

// File: rtl/barrel_rr_pick.sv
// Combinational round-robin picker: the first ready thread after the
// last-issued one, wrapping from NUM_THREADS-1 back to 0.
module barrel_rr_pick
  import barrel_pkg::*;
(
  input  logic [NUM_THREADS-1:0] ready,
  input  tid_t                   last,
  output tid_t                   pick,
  output logic                   any_ready
);

  tid_t cand;

  // Offsets 1..NUM_THREADS; the last offset wraps onto 'last' itself.
  always_comb begin
    pick      = last;
    any_ready = 1'b0;
    cand      = last;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = last + tid_t'(i);
      if (!any_ready && ready[cand]) begin
        pick      = cand;
        any_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrel_thread_sched.sv
// Per-cycle fetch-thread scheduler: round-robin over enabled, unblocked
// threads, with block countdowns, F/D bubble/freeze controls and an idle counter.
module barrel_thread_sched
  import barrel_pkg::*;
#(
  parameter int PERF_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_THREADS-1:0]    thread_en_i,
  input  logic                      stall_i,
  input  logic                      block_req_i,
  input  tid_t                      block_tid_i,
  input  logic [WAIT_CNT_WIDTH-1:0] block_cycles_i,
  output tid_t                      tid_f_o,
  output logic                      issue_valid_o,
  output logic                      stall_o,
  output logic                      clr_fd_o,
  output logic [PERF_WIDTH-1:0]     idle_cycles_o
);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt [NUM_THREADS];
  logic [NUM_THREADS-1:0]    ready;
  tid_t                      last;
  tid_t                      pick;
  logic                      any_ready;

  // A same-cycle block request removes its thread before selection.
  always_comb begin
    ready = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      ready[t] = thread_en_i[t] && (wait_cnt[t] == '0) &&
                 !(block_req_i && (block_tid_i == tid_t'(t)));
    end
  end

  barrel_rr_pick u_pick (
    .ready     (ready),
    .last      (last),
    .pick      (pick),
    .any_ready (any_ready)
  );

  // Freeze reaches the pipe registers in the same cycle.
  assign stall_o = stall_i;

  // Countdowns track real cycles, so they keep running through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) wait_cnt[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (block_req_i && (block_tid_i == tid_t'(t)) && (block_cycles_i != '0))
          wait_cnt[t] <= block_cycles_i;
        else if (wait_cnt[t] != '0)
          wait_cnt[t] <= wait_cnt[t] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_f_o       <= '0;
      last          <= tid_t'(NUM_THREADS - 1);
      issue_valid_o <= 1'b0;
      clr_fd_o      <= 1'b0;
      idle_cycles_o <= '0;
    end else if (!stall_i) begin
      if (any_ready) begin
        tid_f_o       <= pick;
        last          <= pick;
        issue_valid_o <= 1'b1;
        clr_fd_o      <= 1'b0;
      end else begin
        issue_valid_o <= 1'b0;
        clr_fd_o      <= 1'b1;
        if (idle_cycles_o != '1)
          idle_cycles_o <= idle_cycles_o + PERF_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Directed bench for barrel_thread_sched: reset, round-robin order, blocking,
// idle bubbles, stall hold and mid-run reset against hand-computed sequences.
module tb_barrel_thread_sched;
  import barrel_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_THREADS-1:0]    thread_en_i;
  logic                      stall_i;
  logic                      block_req_i;
  tid_t                      block_tid_i;
  logic [WAIT_CNT_WIDTH-1:0] block_cycles_i;
  tid_t                      tid_f_o;
  logic                      issue_valid_o;
  logic                      stall_o;
  logic                      clr_fd_o;
  logic [31:0]               idle_cycles_o;

  int vectors     = 0;
  int miscompares = 0;

  barrel_thread_sched #(.PERF_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .thread_en_i    (thread_en_i),
    .stall_i        (stall_i),
    .block_req_i    (block_req_i),
    .block_tid_i    (block_tid_i),
    .block_cycles_i (block_cycles_i),
    .tid_f_o        (tid_f_o),
    .issue_valid_o  (issue_valid_o),
    .stall_o        (stall_o),
    .clr_fd_o       (clr_fd_o),
    .idle_cycles_o  (idle_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; thread_en_i = 8'hFF; stall_i = 1'b0;
    block_req_i = 1'b0; block_tid_i = '0; block_cycles_i = '0;
    #2;
    vectors++;
    if (tid_f_o !== 3'd0) begin miscompares++; $display("FAIL reset_tid got %0d want 0", tid_f_o); end
    vectors++;
    if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", issue_valid_o); end
    vectors++;
    if (clr_fd_o !== 1'b0) begin miscompares++; $display("FAIL reset_clr got %b want 0", clr_fd_o); end
    vectors++;
    if (idle_cycles_o !== 32'd0) begin miscompares++; $display("FAIL reset_idle got %0d want 0", idle_cycles_o); end
    tick(); tick();
    vectors++;
    if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_hold_valid got %b want 0", issue_valid_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int   exp_seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    tid_t e;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = tid_t'(exp_seq[i]);
      vectors++;
      if (tid_f_o !== e || issue_valid_o !== 1'b1 || clr_fd_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_seq[%0d] got tid=%0d v=%b clr=%b want tid=%0d v=1 clr=0",
                 i, tid_f_o, issue_valid_o, clr_fd_o, e);
      end
    end
  endtask

  task automatic test_alternate();
    int   exp_seq [4] = '{2, 0, 2, 0};
    tid_t e;
    thread_en_i = 8'b0000_0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = tid_t'(exp_seq[i]);
      vectors++;
      if (tid_f_o !== e || issue_valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL alt_seq[%0d] got tid=%0d v=%b want tid=%0d v=1", i, tid_f_o, issue_valid_o, e);
      end
    end
    vectors++;
    if (idle_cycles_o !== 32'd0) begin miscompares++; $display("FAIL alt_idle got %0d want 0", idle_cycles_o); end
  endtask

  task automatic test_block();
    int   exp_seq [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    tid_t e;
    thread_en_i = 8'hFF;
    tick();
    vectors++;
    if (tid_f_o !== 3'd1) begin miscompares++; $display("FAIL blk_pre1 got %0d want 1", tid_f_o); end
    tick();
    vectors++;
    if (tid_f_o !== 3'd2) begin miscompares++; $display("FAIL blk_pre2 got %0d want 2", tid_f_o); end
    block_req_i = 1'b1; block_tid_i = 3'd3; block_cycles_i = 4'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      block_req_i = 1'b0;
      e = tid_t'(exp_seq[i]);
      vectors++;
      if (tid_f_o !== e) begin
        miscompares++;
        $display("FAIL blk_seq[%0d] got %0d want %0d", i, tid_f_o, e);
      end
    end
  endtask

  task automatic test_idle();
    thread_en_i = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (issue_valid_o !== 1'b0 || clr_fd_o !== 1'b1 || tid_f_o !== 3'd3 ||
          idle_cycles_o !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL idle[%0d] got v=%b clr=%b tid=%0d idle=%0d want v=0 clr=1 tid=3 idle=%0d",
                 i, issue_valid_o, clr_fd_o, tid_f_o, idle_cycles_o, i + 1);
      end
    end
    thread_en_i = 8'b0100_0000;
    tick();
    vectors++;
    if (tid_f_o !== 3'd6 || issue_valid_o !== 1'b1 || clr_fd_o !== 1'b0 || idle_cycles_o !== 32'd5) begin
      miscompares++;
      $display("FAIL idle_reenable got tid=%0d v=%b clr=%b idle=%0d want tid=6 v=1 clr=0 idle=5",
               tid_f_o, issue_valid_o, clr_fd_o, idle_cycles_o);
    end
  endtask

  task automatic test_stall();
    int   exp_seq [3] = '{6, 7, 0};
    tid_t e;
    thread_en_i = 8'hFF;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (tid_f_o !== 3'd4) begin miscompares++; $display("FAIL stall_pre got %0d want 4", tid_f_o); end
    // Thread 0 blocked for 5 at the edge that issues 5
    block_req_i = 1'b1; block_tid_i = 3'd0; block_cycles_i = 4'd5;
    tick();
    block_req_i = 1'b0;
    vectors++;
    if (tid_f_o !== 3'd5) begin miscompares++; $display("FAIL stall_entry got %0d want 5", tid_f_o); end
    stall_i = 1'b1;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin miscompares++; $display("FAIL stall_pass got %b want 1", stall_o); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) thread_en_i = 8'h00;
      tick();
      vectors++;
      if (tid_f_o !== 3'd5 || issue_valid_o !== 1'b1 || clr_fd_o !== 1'b0 ||
          stall_o !== 1'b1 || idle_cycles_o !== 32'd5) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got tid=%0d v=%b clr=%b so=%b idle=%0d want tid=5 v=1 clr=0 so=1 idle=5",
                 i, tid_f_o, issue_valid_o, clr_fd_o, stall_o, idle_cycles_o);
      end
    end
    stall_i = 1'b0; thread_en_i = 8'hFF;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b want 0", stall_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = tid_t'(exp_seq[i]);
      vectors++;
      if (tid_f_o !== e) begin
        miscompares++;
        $display("FAIL stall_after[%0d] got %0d want %0d", i, tid_f_o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   exp_seq [3] = '{0, 1, 2};
    tid_t e;
    block_req_i = 1'b1; block_tid_i = 3'd1; block_cycles_i = 4'd15;
    tick();
    block_req_i = 1'b0;
    vectors++;
    if (tid_f_o !== 3'd2) begin miscompares++; $display("FAIL rmid_skip got %0d want 2", tid_f_o); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tid_f_o !== 3'd0 || issue_valid_o !== 1'b0 || clr_fd_o !== 1'b0 || idle_cycles_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rmid_async got tid=%0d v=%b clr=%b idle=%0d want all 0",
               tid_f_o, issue_valid_o, clr_fd_o, idle_cycles_o);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = tid_t'(exp_seq[i]);
      vectors++;
      if (tid_f_o !== e || issue_valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_seq[%0d] got tid=%0d v=%b want tid=%0d v=1", i, tid_f_o, issue_valid_o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_block();
    test_idle();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_thread_sched.md
Name: barrel_thread_sched

Overview:
Per-cycle thread scheduler for the barrel RISC-V core. It picks the hardware thread that fetches each cycle, round-robin over threads that are enabled and not blocked. It tracks per-thread block countdowns requested by the memory stage, and it drives bubble and freeze controls for the tid-carrying pipeline registers (F/D through M/W). The selected tid enters at fetch and travels down the pipeline with each instruction.

Parameters:
BITS_THREADS, 3, tid width
NUM_THREADS, 2**BITS_THREADS, thread count (derived; not overridden)
WAIT_CNT_WIDTH, 4, width of the per-thread block countdown
PERF_WIDTH, 32, width of the idle-cycle counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
thread_en_i  in  NUM_THREADS  per-thread enable mask (CSR-driven)
stall_i  in  1  hazard freeze from hazard unit
block_req_i  in  1  M-stage request to block a thread
block_tid_i  in  BITS_THREADS  thread to block
block_cycles_i  in  WAIT_CNT_WIDTH  block duration in cycles
tid_f_o  out  BITS_THREADS  thread selected for fetch
issue_valid_o  out  1  tid_f_o is a real issue slot
stall_o  out  1  freeze for pipe-register en pins (high = hold)
clr_fd_o  out  1  bubble into the F/D register
idle_cycles_o  out  PERF_WIDTH  count of cycles with no ready thread

Behaviour:
- Reset (rst_n low, async): tid_f_o=0, issue_valid_o=0, clr_fd_o=0, idle_cycles_o=0, all wait_cnt=0, last-issued pointer=NUM_THREADS-1, so the first pick is thread 0.
- Ready definition: ready[t] = thread_en_i[t] & (wait_cnt[t]==0) & ~(block_req_i & block_tid_i==t).
  - A block request in the same cycle excludes that thread immediately; block wins over selection.
- Selection: combinational round-robin search starting at last+1 mod NUM_THREADS.
  - The pointer wraps from NUM_THREADS-1 to 0.
  - The first ready thread is the pick.
- All outputs are registered. A change in ready state affects tid_f_o on the next rising edge (1-cycle latency).
- On each rising edge with stall_i=0 and at least one thread ready:
  - tid_f_o <= pick, last <= pick
  - issue_valid_o <= 1, clr_fd_o <= 0
- On each rising edge with stall_i=0 and no thread ready:
  - tid_f_o and last hold
  - issue_valid_o <= 0, clr_fd_o <= 1
  - idle_cycles_o increments, saturating at all-ones.
- On each rising edge with stall_i=1:
  - tid_f_o, last, issue_valid_o and clr_fd_o hold.
  - stall_o follows stall_i registered-free (combinational passthrough), so pipe registers freeze in the same cycle.
  - The idle counter does not count while stall_i=1.
- Block countdowns:
  - block_req_i with block_cycles_i != 0 loads wait_cnt[block_tid_i] <= block_cycles_i.
  - block_cycles_i == 0 is a no-op.
  - A new request on an already-blocked thread overwrites its count.
  - Each nonzero wait_cnt decrements by 1 every cycle, including stall cycles (it counts real cycles).
  - A load overrides the decrement for the same thread in the same cycle.
  - A thread blocked for N cycles at edge k becomes ready when its count reaches 0, i.e. it is eligible for selection N cycles after the load edge.
- thread_en_i deassert: the thread is dropped from the next selection. Its wait_cnt keeps counting.
- Single-thread case: if only thread t is ready, t issues every cycle. Pipeline hazard handling is the hazard unit's job, not this block's.
- Reset mid-operation clears all countdowns and the pointer. No state survives reset.

Decomposition:
- Shared package barrel_pkg:
  - BITS_THREADS and NUM_THREADS constants
  - tid_t typedef
  - WAIT_CNT_WIDTH
- One sub-module, barrel_rr_pick: purely combinational, (ready vector, last pointer) -> (pick, any_ready).
- Countdowns, registers and the perf counter stay in barrel_thread_sched.

Test Plan:
- Reset release, thread_en_i=8'hFF, stall_i=0 -> tid_f_o sequence 0,1,2,…,7,0,1 on consecutive edges; issue_valid_o=1 from the first edge; clr_fd_o=0.
- thread_en_i=8'b0000_0101 -> tid_f_o alternates 0,2,0,2; no idle cycles counted.
- All enabled; block_req_i with tid=3, cycles=4 asserted on the edge where pick would be 3 -> 3 is skipped (2 then 4). Thread 3 reappears at its first round-robin slot after its count reaches 0.
- thread_en_i=8'h00 for 5 cycles -> issue_valid_o=0, clr_fd_o=1, idle_cycles_o reaches 5. Re-enabling only thread 6 -> tid_f_o=6, issue_valid_o=1 next edge.
- Stall while tid_f_o=5, stall_i=1 for 3 cycles -> stall_o=1 for those cycles, tid_f_o holds 5, then continues 6. A countdown loaded before the stall keeps decrementing during it.
- Thread 1 blocked for 15 cycles, rst_n pulsed low mid-countdown -> outputs immediately at reset values; after release, sequence restarts at 0 and includes 1 without waiting.
